// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_arb_pkg;

    // Register 31 is hardwired to zero; writes to it are discarded.
    localparam logic [4:0] REG_ZERO = 5'd31;
    localparam int         NUM_REGS = 32;

    // Which requester owns the write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_MC
    } grant_t;

endpackage : regfile_arb_pkg

// File: rtl/regfile_wr_arbiter_if.sv
// Write-request channels of the two requesters (WB and MC) that share the
// register-file write port. Each channel is a valid/ready handshake.
interface regfile_wr_arbiter_if #(
    parameter int DATA_W = 64
);

    logic              wb_valid;
    logic              wb_ready;
    logic [4:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;

    logic              mc_valid;
    logic              mc_ready;
    logic [4:0]        mc_reg;
    logic [DATA_W-1:0] mc_data;

    // The requesters present writes and receive ready.
    modport master (
        output wb_valid, wb_reg, wb_data,
        output mc_valid, mc_reg, mc_data,
        input  wb_ready, mc_ready
    );

    // The arbiter accepts writes and returns ready.
    modport slave (
        input  wb_valid, wb_reg, wb_data,
        input  mc_valid, mc_reg, mc_data,
        output wb_ready, mc_ready
    );

endinterface : regfile_wr_arbiter_if

// File: rtl/regfile_wr_arbiter_scoreboard.sv
// Busy scoreboard: one bit per architectural register, set when a
// multi-cycle op that targets it issues, cleared when its result is written.
module reg_scoreboard
    import regfile_arb_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [4:0]          set_reg,
    input  logic                clr_en,
    input  logic [4:0]          clr_reg,
    output logic [NUM_REGS-1:0] busy
);

    // Per-register set/clear; a set on the same register as a clear wins
    // because the newly issued op now owns that destination.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                // NOTE: non-blocking assignment for every flop; blocking here would let later logic in the same edge see the new value.
                if (set_en && set_reg == 5'(r)) begin
                    busy[r] <= 1'b1;
                end else if (clr_en && clr_reg == 5'(r)) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

endmodule : reg_scoreboard

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between the writeback
// stage (WB) and the multi-cycle unit (MC), registers the winning write,
// and tracks destinations owned by in-flight MC ops for the decode stall.
module regfile_wr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wr_arbiter_if.slave req,
    input  logic                mc_issue_valid,
    input  logic [4:0]          mc_issue_reg,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    output logic                src_stall,
    output logic [NUM_REGS-1:0] busy,
    output logic                RegWrite,
    output logic [4:0]          WriteRegister,
    output logic [DATA_W-1:0]   WriteData,
    output logic                starve_force
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  cnt;
    grant_t            gnt;
    logic [4:0]        sel_reg;
    logic [DATA_W-1:0] sel_data;

    assign starve_force = (cnt == CNT_W'(STARVE_LIMIT)) && req.mc_valid;

    // Priority select: starving MC first, then WB, then MC.
    always_comb begin
        // NOTE: default assignment first so every path drives gnt and no latch is inferred.
        gnt = GNT_NONE;
        if (starve_force) begin
            gnt = GNT_MC;
        end else if (req.wb_valid) begin
            gnt = GNT_WB;
        end else if (req.mc_valid) begin
            gnt = GNT_MC;
        end
    end

    assign req.wb_ready = (gnt == GNT_WB);
    assign req.mc_ready = (gnt == GNT_MC);

    // Route the winner's destination and data toward the output register.
    always_comb begin
        sel_reg  = req.wb_reg;
        sel_data = req.wb_data;
        if (gnt == GNT_MC) begin
            sel_reg  = req.mc_reg;
            sel_data = req.mc_data;
        end
    end

    // Count consecutive MC losses, saturating at the force threshold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (req.mc_valid && !req.mc_ready) begin
            if (cnt != CNT_W'(STARVE_LIMIT)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // Register the granted write; register 31 is accepted but never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (gnt != GNT_NONE) begin
            RegWrite      <= (sel_reg != REG_ZERO);
            WriteRegister <= sel_reg;
            WriteData     <= sel_data;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

    reg_scoreboard u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (mc_issue_valid && (mc_issue_reg != REG_ZERO)),
        .set_reg (mc_issue_reg),
        .clr_en  (req.mc_ready),
        .clr_reg (req.mc_reg),
        .busy    (busy)
    );

    // Decode stalls on the current busy vector, not on a same-cycle clear.
    assign src_stall = busy[rs1] | busy[rs2];

endmodule : regfile_wr_arbiter

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: inputs change 1 ns after a rising
// edge, combinational outputs are sampled 1 ns later, registered outputs
// 1 ns after the following rising edge.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mc_issue_valid;
    logic [4:0]  mc_issue_reg;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        src_stall;
    logic [31:0] busy;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic        starve_force;

    int n_vec = 0;
    int n_err = 0;

    regfile_wr_arbiter_if #(.DATA_W(64)) bus ();

    regfile_wr_arbiter #(.DATA_W(64), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (bus.slave),
        .mc_issue_valid (mc_issue_valid),
        .mc_issue_reg   (mc_issue_reg),
        .rs1            (rs1),
        .rs2            (rs2),
        .src_stall      (src_stall),
        .busy           (busy),
        .RegWrite       (RegWrite),
        .WriteRegister  (WriteRegister),
        .WriteData      (WriteData),
        .starve_force   (starve_force)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_valid   = 1'b0;
        bus.wb_reg     = '0;
        bus.wb_data    = '0;
        bus.mc_valid   = 1'b0;
        bus.mc_reg     = '0;
        bus.mc_data    = '0;
        mc_issue_valid = 1'b0;
        mc_issue_reg   = '0;
    endtask

    initial begin
        reset = 1'b0;
        rs1   = '0;
        rs2   = '0;
        idle_inputs();
        #1;
        check("rst_regwrite", RegWrite, 0);
        check("rst_wreg", WriteRegister, 0);
        check("rst_wdata", WriteData, 0);
        check("rst_busy", busy, 0);
        check("rst_wb_ready", bus.wb_ready, 0);
        check("rst_mc_ready", bus.mc_ready, 0);
        check("rst_stall", src_stall, 0);
        check("rst_starve", starve_force, 0);
        tick();
        reset = 1'b1;

        // Single WB write, one-cycle latency.
        tick();
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'd5;
        bus.wb_data  = 64'hDEAD_BEEF;
        #1;
        check("wb_ready", bus.wb_ready, 1);
        check("wb_mc_ready", bus.mc_ready, 0);
        tick();
        idle_inputs();
        #1;
        check("wb_regwrite", RegWrite, 1);
        check("wb_wreg", WriteRegister, 5);
        check("wb_wdata", WriteData, 64'hDEAD_BEEF);
        tick();
        check("idle_regwrite", RegWrite, 0);
        check("idle_hold_wreg", WriteRegister, 5);
        check("idle_hold_wdata", WriteData, 64'hDEAD_BEEF);

        // Both valid for six cycles: WB x4, forced MC, then WB again.
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'd3;
        bus.wb_data  = 64'hAAAA;
        bus.mc_valid = 1'b1;
        bus.mc_reg   = 5'd7;
        bus.mc_data  = 64'hBBBB;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("arb%0d_wb_ready", i), bus.wb_ready, (i != 4));
            check($sformatf("arb%0d_mc_ready", i), bus.mc_ready, (i == 4));
            check($sformatf("arb%0d_starve", i), starve_force, (i == 4));
            tick();
            #1;
            check($sformatf("arb%0d_wreg", i), WriteRegister, (i == 4) ? 7 : 3);
            check($sformatf("arb%0d_wdata", i), WriteData, (i == 4) ? 64'hBBBB : 64'hAAAA);
        end
        idle_inputs();
        tick();

        // Write to the zero register is granted but not performed.
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'd31;
        bus.wb_data  = 64'h1;
        #1;
        check("r31_wb_ready", bus.wb_ready, 1);
        tick();
        idle_inputs();
        #1;
        check("r31_regwrite", RegWrite, 0);

        // Scoreboard set, stall, clear by MC write.
        mc_issue_valid = 1'b1;
        mc_issue_reg   = 5'd9;
        tick();
        mc_issue_valid = 1'b0;
        rs1            = 5'd9;
        #1;
        check("sb_busy9", busy, 32'h0000_0200);
        check("sb_stall", src_stall, 1);
        bus.mc_valid = 1'b1;
        bus.mc_reg   = 5'd9;
        bus.mc_data  = 64'h1234_5678;
        #1;
        check("sb_mc_ready", bus.mc_ready, 1);
        check("sb_stall_no_bypass", src_stall, 1);
        tick();
        idle_inputs();
        #1;
        check("sb_busy_clr", busy, 0);
        check("sb_stall_clr", src_stall, 0);
        check("sb_regwrite", RegWrite, 1);
        check("sb_wreg", WriteRegister, 9);
        check("sb_wdata", WriteData, 64'h1234_5678);

        // Issue to register 31 never marks it busy.
        mc_issue_valid = 1'b1;
        mc_issue_reg   = 5'd31;
        tick();
        idle_inputs();
        check("sb_r31_busy", busy, 0);

        // Same-edge set and clear of register 12: set wins.
        mc_issue_valid = 1'b1;
        mc_issue_reg   = 5'd12;
        bus.mc_valid   = 1'b1;
        bus.mc_reg     = 5'd12;
        bus.mc_data    = 64'h12;
        #1;
        check("sw_mc_ready", bus.mc_ready, 1);
        tick();
        idle_inputs();
        check("sw_busy12", busy, 32'h0000_1000);

        // Build busy = 0x210 and a partial starvation count, then reset mid-cycle.
        mc_issue_valid = 1'b1;
        mc_issue_reg   = 5'd4;
        bus.mc_valid   = 1'b1;
        bus.mc_reg     = 5'd12;
        bus.mc_data    = 64'h0;
        tick();
        mc_issue_reg   = 5'd9;
        bus.wb_valid   = 1'b1;
        bus.wb_reg     = 5'd6;
        bus.wb_data    = 64'hC0FFEE;
        bus.mc_reg     = 5'd20;
        tick();
        mc_issue_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", busy, 32'h0000_0210);
        check("pre_rst_regwrite", RegWrite, 1);
        check("pre_rst_wreg", WriteRegister, 6);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_regwrite", RegWrite, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_wreg", WriteRegister, 0);
        check("async_rst_wdata", WriteData, 0);
        check("async_rst_stall", src_stall, 0);
        check("async_rst_starve", starve_force, 0);
        #1;
        reset = 1'b1;
        #1;
        // Counter restarted from 0: four more WB wins before MC is forced.
        for (int i = 0; i < 5; i++) begin
            check($sformatf("post_rst%0d_starve", i), starve_force, (i == 4));
            check($sformatf("post_rst%0d_wb_ready", i), bus.wb_ready, (i != 4));
            tick();
        end
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile_wr_arbiter

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the pipeline writeback stage (WB);
  - the multi-cycle unit (MC), i.e. the divider and load-miss return.
- Registers the winning write and drives RegWrite/WriteRegister/WriteData of the 32x64 register file.
- Keeps a busy scoreboard of destinations owned by in-flight MC ops, which feeds the decode-stage stall.

Parameters:
DATA_W, 64, write data width; matches regfile.
STARVE_LIMIT, 4, consecutive MC losses before MC is forced to win.
CNT_W, $clog2(STARVE_LIMIT+1), starvation counter width (derived, not overridden).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
wb_valid  in  1  WB write request
wb_ready  out  1  WB request granted this cycle
wb_reg  in  5  WB destination
wb_data  in  DATA_W  WB data
mc_valid  in  1  MC write request
mc_ready  out  1  MC request granted this cycle
mc_reg  in  5  MC destination
mc_data  in  DATA_W  MC data
mc_issue_valid  in  1  multi-cycle op issued this cycle
mc_issue_reg  in  5  destination of issued op
rs1, rs2  in  5 each  decode-stage source registers
src_stall  out  1  rs1 or rs2 is busy
busy  out  32  scoreboard vector
RegWrite  out  1  to regfile
WriteRegister  out  5  to regfile
WriteData  out  DATA_W  to regfile
starve_force  out  1  MC forced-priority active this cycle

Behaviour:
- Reset (reset=0, async) clears:
  - RegWrite, WriteRegister, WriteData to 0;
  - busy to 0;
  - starvation counter to 0.
- wb_ready, mc_ready, src_stall and starve_force are combinational, so all read 0 while reset is held and no request is present.
- Handshake:
  - valid/ready; transfer occurs when valid && ready in the same cycle.
  - The requester holds reg/data stable until ready.
  - ready depends on valid and the counter only, never on data.
  - At most one ready is high per cycle.
- Arbitration (combinational):
  - starve_force = (cnt == STARVE_LIMIT) && mc_valid.
  - If starve_force, grant MC.
  - Else if wb_valid, grant WB.
  - Else if mc_valid, grant MC.
  - Else no grant.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when mc_valid && !mc_ready.
  - Clears on MC grant or when mc_valid=0.
- Output stage:
  - A grant at edge k produces RegWrite=1 with the granted reg/data for the cycle after edge k; the regfile captures at edge k+1. Latency is 1 cycle.
  - With no grant, RegWrite=0 next cycle and WriteRegister/WriteData hold their previous values.
- Register 31 (hardwired zero):
  - A request to reg 31 is granted normally, but RegWrite is forced to 0.
  - mc_issue_reg=31 never sets busy.
- Scoreboard:
  - busy[r] is set at the edge where mc_issue_valid && mc_issue_reg==r.
  - It is cleared at the edge where an MC write to r is granted.
  - Simultaneous set and clear of the same r: set wins, because a new op now owns r.
  - WB grants never touch busy.
- src_stall = busy[rs1] | busy[rs2], combinational from the current busy vector. It is not bypassed by the same-cycle clear.
- Reset mid-operation: all in-flight grants are lost and busy clears; requesters must re-present after reset.

Decomposition:
- Package regfile_arb_pkg:
  - constants REG_ZERO=5'd31 and NUM_REGS=32;
  - enum grant_t {GNT_NONE, GNT_WB, GNT_MC}.
- Sub-module reg_scoreboard holds busy[31:0] with set/clear ports and the set-wins rule.
  - Ports: set_en, set_reg, clr_en, clr_reg, busy.
- Arbitration, the starvation counter and the output register stay in the top module.

Test Plan:
- Reset released, wb_valid=1, wb_reg=5, wb_data=64'hDEAD_BEEF -> wb_ready=1 same cycle; next cycle RegWrite=1, WriteRegister=5, WriteData=DEAD_BEEF.
- Both valid (wb_reg=3, mc_reg=7) for 6 cycles, STARVE_LIMIT=4 -> WB granted cycles 0-3; cycle 4 starve_force=1, mc_ready=1, wb_ready=0; counter returns to 0 and WB wins again from cycle 5.
- wb_reg=31, data=64'h1 -> wb_ready=1; next cycle RegWrite=0.
- mc_issue_reg=9, then rs1=9 -> busy[9]=1, src_stall=1; MC write to reg 9 granted -> busy[9]=0 next cycle, src_stall=0.
- Same cycle: mc_issue_reg=12 and MC write to reg 12 granted -> busy[12] remains 1.
- Assert reset=0 mid-burst with busy=32'h0000_0210 and RegWrite=1 -> immediately RegWrite=0, busy=0, counter=0 without waiting for a clock edge.
